// File: rtl/pe_array_pkg.sv
// Shared types and constants for the PE array sequencer.
// Holds the FSM state encoding, pipeline latencies and the array-dimension helper.
package pe_array_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FEED,
      ST_DRAIN,
      ST_FLUSH,
      ST_TAIL,
      ST_DONE
   } state_e;

   localparam int SRAM_RD_LAT = 1;
   localparam int WB_LAT      = 2;

   function automatic int max_dim(input int rows, input int cols);
      return (rows > cols) ? rows : cols;
   endfunction

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Job, SRAM and array-facing signal bundle of the PE array sequencer.
// The scheduler/array side uses master; the sequencer uses slave.
interface pe_array_ctrl_if #(
   parameter int PE_ARRAY_NUM_ROWS = 32,
   parameter int PE_ARRAY_NUM_COLS = 32,
   parameter int K_BWIDTH          = 10,
   parameter int ADDR_BWIDTH       = 10
);
   logic                         START_in;
   logic [K_BWIDTH-1:0]          K_LEN_in;
   logic [ADDR_BWIDTH-1:0]       OPND1_BASE_in;
   logic [ADDR_BWIDTH-1:0]       OPND2_BASE_in;
   logic [ADDR_BWIDTH-1:0]       OUT_BASE_in;
   logic                         STALL_in;

   logic                         BUSY_out;
   logic                         DONE_out;
   logic                         OPND1_RD_EN_out;
   logic                         OPND2_RD_EN_out;
   logic [ADDR_BWIDTH-1:0]       OPND1_RD_ADDR_out;
   logic [ADDR_BWIDTH-1:0]       OPND2_RD_ADDR_out;
   logic                         OUT_WR_EN_out;
   logic [ADDR_BWIDTH-1:0]       OUT_WR_ADDR_out;
   logic                         STALL_out;
   logic                         IS_COMPUTING_out;
   logic                         IS_FLUSHING_out;
   logic [PE_ARRAY_NUM_ROWS-1:0] OPND1_IS_VALID_out;
   logic [PE_ARRAY_NUM_COLS-1:0] OPND2_IS_VALID_out;

   modport master (
      output START_in, K_LEN_in, OPND1_BASE_in, OPND2_BASE_in, OUT_BASE_in, STALL_in,
      input  BUSY_out, DONE_out, OPND1_RD_EN_out, OPND2_RD_EN_out,
             OPND1_RD_ADDR_out, OPND2_RD_ADDR_out, OUT_WR_EN_out, OUT_WR_ADDR_out,
             STALL_out, IS_COMPUTING_out, IS_FLUSHING_out,
             OPND1_IS_VALID_out, OPND2_IS_VALID_out
   );

   modport slave (
      input  START_in, K_LEN_in, OPND1_BASE_in, OPND2_BASE_in, OUT_BASE_in, STALL_in,
      output BUSY_out, DONE_out, OPND1_RD_EN_out, OPND2_RD_EN_out,
             OPND1_RD_ADDR_out, OPND2_RD_ADDR_out, OUT_WR_EN_out, OUT_WR_ADDR_out,
             STALL_out, IS_COMPUTING_out, IS_FLUSHING_out,
             OPND1_IS_VALID_out, OPND2_IS_VALID_out
   );

endinterface

// File: rtl/pe_skew_mask_gen.sv
// Registered diagonal valid-window mask: bit r is set for read slot t when r <= t <= r+K-1.
// The register stage lines the mask up with operand data returning from the SRAM.
module pe_skew_mask_gen #(
   parameter int N        = 32,
   parameter int K_BWIDTH = 10,
   parameter int CNT_W    = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                en,
   input  logic                active,
   input  logic [CNT_W-1:0]    t,
   input  logic [K_BWIDTH-1:0] k,
   output logic [N-1:0]        mask
);

   logic [N-1:0] mask_d;

   always_comb begin
      mask_d = '0;
      if (active) begin
         for (int r = 0; r < N; r++) begin
            if ((t >= CNT_W'(r)) && ((t - CNT_W'(r)) < CNT_W'(k))) begin
               mask_d[r] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         mask <= '0;
      end else if (en) begin
         mask <= mask_d;
      end
   end

endmodule

// File: rtl/pe_array_ctrl.sv
// Tile-job sequencer for the output-stationary INT8 PE array: feeds skewed operands,
// lets products settle, flushes accumulators row by row into the output SRAM.
//
// state | meaning
// IDLE  | waiting for START; config latched on accept
// FEED  | K+M-1 operand reads, t is the read slot / diagonal index
// DRAIN | ROWS+COLS-1 cycles for the last products to propagate
// FLUSH | ROWS cycles, one accumulator row shifted out per cycle
// TAIL  | covers write-back latency of the last flushed rows
// DONE  | one-cycle completion pulse
module pe_array_ctrl
   import pe_array_pkg::*;
#(
   parameter int PE_ARRAY_NUM_ROWS = 32,
   parameter int PE_ARRAY_NUM_COLS = 32,
   parameter int K_BWIDTH          = 10,
   parameter int ADDR_BWIDTH       = 10
) (
   input logic            CLK,
   input logic            RST,
   pe_array_ctrl_if.slave bus
);

   localparam int ROWS  = PE_ARRAY_NUM_ROWS;
   localparam int COLS  = PE_ARRAY_NUM_COLS;
   localparam int M     = max_dim(ROWS, COLS);
   localparam int CNT_W = K_BWIDTH + $clog2(M) + 2;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       t_q, t_d;
   logic [K_BWIDTH-1:0]    k_q;
   logic [ADDR_BWIDTH-1:0] opnd1_base_q, opnd2_base_q, out_base_q;
   logic                   run;
   logic                   accept;
   logic [CNT_W-1:0]       feed_last;
   logic                   is_computing_q, is_flushing_q;
   logic                   feeding;
   logic [WB_LAT-1:0]      wb_vld_q;
   logic [ADDR_BWIDTH-1:0] wb_addr_q [WB_LAT];

   assign run       = ~bus.STALL_in;
   assign accept    = (state_q == ST_IDLE) && bus.START_in;
   assign feed_last = CNT_W'(k_q) + CNT_W'(M - 2);
   assign feeding   = (state_q == ST_FEED);

   always_comb begin
      state_d = state_q;
      t_d     = t_q + CNT_W'(1);
      case (state_q)
         ST_IDLE: begin
            t_d = '0;
            if (bus.START_in) begin
               state_d = (bus.K_LEN_in == '0) ? ST_DONE : ST_FEED;
            end
         end
         ST_FEED: begin
            if (t_q == feed_last) begin
               state_d = ST_DRAIN;
               t_d     = '0;
            end
         end
         ST_DRAIN: begin
            if (t_q == CNT_W'(ROWS + COLS - 2)) begin
               state_d = ST_FLUSH;
               t_d     = '0;
            end
         end
         ST_FLUSH: begin
            if (t_q == CNT_W'(ROWS - 1)) begin
               state_d = ST_TAIL;
               t_d     = '0;
            end
         end
         ST_TAIL: begin
            if (t_q == CNT_W'(WB_LAT - 1)) begin
               state_d = ST_DONE;
               t_d     = '0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            t_d     = '0;
         end
         default: begin
            state_d = ST_IDLE;
            t_d     = '0;
         end
      endcase
   end

   // Stall freezes every register; reset still wins.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q        <= ST_IDLE;
         t_q            <= '0;
         k_q            <= '0;
         opnd1_base_q   <= '0;
         opnd2_base_q   <= '0;
         out_base_q     <= '0;
         is_computing_q <= 1'b0;
         is_flushing_q  <= 1'b0;
      end else if (run) begin
         state_q        <= state_d;
         t_q            <= t_d;
         is_computing_q <= (state_q == ST_FEED) || (state_q == ST_DRAIN);
         is_flushing_q  <= (state_q == ST_FLUSH);
         if (accept) begin
            k_q          <= bus.K_LEN_in;
            opnd1_base_q <= bus.OPND1_BASE_in;
            opnd2_base_q <= bus.OPND2_BASE_in;
            out_base_q   <= bus.OUT_BASE_in;
         end
      end
   end

   // Write-back pipe: flushed row i reaches the output SRAM port WB_LAT cycles later.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wb_vld_q <= '0;
         for (int i = 0; i < WB_LAT; i++) begin
            wb_addr_q[i] <= '0;
         end
      end else if (run) begin
         wb_vld_q[0]  <= (state_q == ST_FLUSH);
         wb_addr_q[0] <= out_base_q + ADDR_BWIDTH'(t_q);
         for (int i = 1; i < WB_LAT; i++) begin
            wb_vld_q[i]  <= wb_vld_q[i-1];
            wb_addr_q[i] <= wb_addr_q[i-1];
         end
      end
   end

   pe_skew_mask_gen #(.N(ROWS), .K_BWIDTH(K_BWIDTH), .CNT_W(CNT_W)) u_row_mask (
      .CLK    (CLK),
      .RST    (RST),
      .en     (run),
      .active (feeding),
      .t      (t_q),
      .k      (k_q),
      .mask   (bus.OPND1_IS_VALID_out)
   );

   pe_skew_mask_gen #(.N(COLS), .K_BWIDTH(K_BWIDTH), .CNT_W(CNT_W)) u_col_mask (
      .CLK    (CLK),
      .RST    (RST),
      .en     (run),
      .active (feeding),
      .t      (t_q),
      .k      (k_q),
      .mask   (bus.OPND2_IS_VALID_out)
   );

   assign bus.BUSY_out          = (state_q != ST_IDLE);
   assign bus.DONE_out          = (state_q == ST_DONE) && run;
   assign bus.OPND1_RD_EN_out   = feeding;
   assign bus.OPND2_RD_EN_out   = feeding;
   assign bus.OPND1_RD_ADDR_out = feeding ? (opnd1_base_q + ADDR_BWIDTH'(t_q)) : '0;
   assign bus.OPND2_RD_ADDR_out = feeding ? (opnd2_base_q + ADDR_BWIDTH'(t_q)) : '0;
   assign bus.OUT_WR_EN_out     = wb_vld_q[WB_LAT-1] && run;
   assign bus.OUT_WR_ADDR_out   = wb_addr_q[WB_LAT-1];
   assign bus.STALL_out         = bus.STALL_in;
   assign bus.IS_COMPUTING_out  = is_computing_q;
   assign bus.IS_FLUSHING_out   = is_flushing_q;

endmodule

// File: doc/pe_array_ctrl.md
# pe_array_ctrl

Sequencer for the output-stationary INT8 PE array. It accepts one matrix-tile job: operand SRAM base addresses and reduction length K. It then issues operand SRAM reads and drives the array's skewed per-row/per-column valid masks plus the compute/flush mode bits. Finally it drains the accumulators row by row into the output SRAM and pulses DONE. It sits between the tile-level job scheduler and one PE array instance with its three SRAMs.

## Interface
- PE_ARRAY_NUM_ROWS, 32, PE rows (≥2)
- PE_ARRAY_NUM_COLS, 32, PE columns (≥2)
- K_BWIDTH, 10, width of reduction-length field
- ADDR_BWIDTH, 10, SRAM address width (all three SRAMs)
- CLK  in  1  clock; everything on rising edge
- RST  in  1  synchronous, active-high reset
- START_in  in  1  job request; accepted only in IDLE
- K_LEN_in  in  K_BWIDTH  reduction length, latched on accepted START
- OPND1_BASE_in / OPND2_BASE_in / OUT_BASE_in  in  ADDR_BWIDTH  base addresses, latched on accepted START
- STALL_in  in  1  global freeze request
- BUSY_out  out  1  high whenever state ≠ IDLE
- DONE_out  out  1  one-cycle job-complete pulse
- OPND1_RD_EN_out / OPND2_RD_EN_out  out  1  operand SRAM read enables
- OPND1_RD_ADDR_out / OPND2_RD_ADDR_out  out  ADDR_BWIDTH  operand read addresses
- OUT_WR_EN_out  out  1  output SRAM write enable
- OUT_WR_ADDR_out  out  ADDR_BWIDTH  output write address
- STALL_out  out  1  to array STALL; equals STALL_in (combinational)
- IS_COMPUTING_out  out  1  to array
- IS_FLUSHING_out  out  1  to array
- OPND1_IS_VALID_out  out  PE_ARRAY_NUM_ROWS  per-row operand-1 valid mask
- OPND2_IS_VALID_out  out  PE_ARRAY_NUM_COLS  per-column operand-2 valid mask

## Operation
- States: IDLE → FEED → DRAIN → FLUSH → TAIL → DONE → IDLE.
- One cycle counter `t` is cleared on every state entry.
- Let M = max(ROWS, COLS).
- IDLE: START_in latches the config and moves to FEED.
  - If K_LEN_in = 0: go directly to DONE; no reads, no writes.
- FEED: lasts FEED_LEN = K + M − 1 cycles (t = 0..FEED_LEN−1).
  - Both RD_EN high.
  - RD_ADDR = base + t. Operands are stored pre-skewed: entry t holds diagonal t.
- Valid masks: row r bit set for the read issued at t iff r ≤ t ≤ r+K−1; column c bit likewise.
- DRAIN: ROWS+COLS−1 cycles. RD_EN low, masks zero; lets the last products propagate.
- FLUSH: ROWS cycles, i = 0..ROWS−1.
- TAIL: 2 cycles, covering write-back latency.
- DONE: 1 cycle, DONE_out high; then IDLE.
- Array-facing outputs (IS_COMPUTING, IS_FLUSHING, both masks) are registered one cycle after the state/counter that produces them. This matches the 1-cycle SRAM read latency.
  - IS_COMPUTING_out = registered (state ∈ {FEED, DRAIN}).
  - IS_FLUSHING_out = registered (state = FLUSH).
- OUT_WR_EN_out is asserted 2 cycles after each FLUSH cycle i, with OUT_WR_ADDR_out = OUT_BASE + i.
  - Bottom row emerges first, so address OUT_BASE+i holds PE row ROWS−1−i.
- Address arithmetic is modulo 2^ADDR_BWIDTH and wraps silently.
- START_in while BUSY is ignored. Config is not re-sampled mid-job.
- STALL_in high freezes the controller:
  - state, counters, all registered outputs, RD_EN and RD_ADDR hold (re-reading the same address is idempotent);
  - OUT_WR_EN_out is forced low during stall and the pending write is issued after release;
  - DONE_out is not emitted during stall and is held until the first unstalled cycle, still as a single-cycle pulse.
- RST wins over everything, including mid-job. No partial writes occur after the reset edge.

## Timing
- Reset values: state IDLE, all outputs 0, all addresses 0, latched config 0.
- START accepted at edge n: FEED occupies cycles n+1..n+FEED_LEN.
- Total job length from accept to DONE pulse (stall-free): FEED_LEN + (ROWS+COLS−1) + ROWS + 2 + 1 cycles.
- Minimum START-to-START spacing: job length + 1 (IDLE cycle after DONE).
- START in the DONE cycle is ignored.

## Structure
- Package pe_array_pkg:
  - state enum (IDLE, FEED, DRAIN, FLUSH, TAIL, DONE);
  - constants SRAM_RD_LAT=1 and WB_LAT=2;
  - function max_dim(ROWS, COLS).
- Sub-module pe_skew_mask_gen, instantiated twice with ROWS or COLS: takes t and K, produces the registered window mask r ≤ t ≤ r+K−1.
- The FSM and counters stay in pe_array_ctrl.

## Test plan
- ROWS=COLS=4, K=3, START at cycle 0 →
  - FEED cycles 1–6, RD_ADDR base+0..5;
  - DRAIN 7–13, FLUSH 14–17, TAIL 18–19, DONE_out at 20;
  - OUT_WR_EN 16–19 with addresses OUT_BASE+0..3.
- Same job: OPND1_IS_VALID_out = 0001 at cycle 2, 0011 at 3, 0111 at 4, 1110 at 5, 1100 at 6, 1000 at 7, 0000 at 8.
- K_LEN=0 START at cycle 0 → DONE_out at cycle 1, no RD_EN or OUT_WR_EN ever asserted, BUSY high only in cycle 1.
- STALL_in high for cycles 15–17 of the first job → every event from cycle 15 on shifts by 3; OUT_WR_EN never high during stall; exactly 4 writes with unchanged addresses.
- OPND1_BASE = 2^ADDR_BWIDTH−2, K=3 → read addresses wrap to 0..3 after max−2, max−1.
- RST high at cycle 10 of a job, with START re-asserted at cycle 12 → all outputs 0 at cycle 11; a full new job runs with no residual writes.
